// File: rtl/instr_sequencer.sv
// Fetch/decode/execute sequencer for the 8-bit core: drives the PC strobes, the memory
// read handshake and the datapath execute pulse. Optional single-step: INSTR_SEQ_STEP_EN.
module instr_sequencer #(
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_run,
`ifdef INSTR_SEQ_STEP_EN
  input  logic             i_step,
`endif
  input  logic [7:0]       i_mem_data,
  input  logic             i_mem_ready,
  output logic             o_mem_req,
  output logic             o_pc_oe,
  output logic             o_pc_incr,
  output logic             o_pc_load,
  output logic [7:0]       o_jump_addr,
  output logic [7:0]       o_ir,
  output logic [7:0]       o_operand,
  output logic             o_exec,
  input  logic             i_exec_done,
  input  logic             i_flag_z,
  input  logic             i_flag_c,
  output logic             o_halted,
  output logic [CNT_W-1:0] o_retired
);

  typedef enum logic [2:0] {
    S_HALT,
    S_FETCH,
    S_DECODE,
    S_OPND,
    S_EXEC,
    S_EXEC_WAIT
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        ir_q, ir_d;
  logic [7:0]        operand_q, operand_d;
  logic [CNT_W-1:0]  retired_q, retired_d;
  logic              run_q;
  logic              retire;
  logic [3:0]        opcode;
  state_t            retire_state;

  assign opcode = ir_q[7:4];

`ifdef INSTR_SEQ_STEP_EN
  logic step_q;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) step_q <= 1'b0;
    else          step_q <= i_step;
  end
`endif

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q   <= S_HALT;
      ir_q      <= 8'h00;
      operand_q <= 8'h00;
      retired_q <= '0;
      run_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      operand_q <= operand_d;
      retired_q <= retired_d;
      run_q     <= i_run;
    end
  end

  always_comb begin
    state_d      = state_q;
    ir_d         = ir_q;
    operand_d    = operand_q;
    retire       = 1'b0;
    o_mem_req    = 1'b0;
    o_pc_incr    = 1'b0;
    o_pc_load    = 1'b0;
    o_exec       = 1'b0;
    o_halted     = 1'b0;
    retire_state = S_FETCH;
`ifdef INSTR_SEQ_STEP_EN
    // Dropping run (or stepping) parks the core after the current instruction.
    if (!i_run) retire_state = S_HALT;
`endif

    case (state_q)
      S_HALT: begin
        o_halted = 1'b1;
        if (i_run && !run_q) state_d = S_FETCH;
`ifdef INSTR_SEQ_STEP_EN
        else if (!i_run && i_step && !step_q) state_d = S_FETCH;
`endif
      end
      S_FETCH: begin
        o_mem_req = 1'b1;
        if (i_mem_ready) begin
          o_pc_incr = 1'b1;
          ir_d      = i_mem_data;
          state_d   = S_DECODE;
        end
      end
      S_DECODE: begin
        case (opcode)
          4'h0: begin
            retire  = 1'b1;
            state_d = retire_state;
          end
          4'hF: begin
            retire  = 1'b1;
            state_d = S_HALT;
          end
          4'h1, 4'h2, 4'h3, 4'h4: state_d = S_OPND;
          default: state_d = S_EXEC;
        endcase
      end
      S_OPND: begin
        o_mem_req = 1'b1;
        if (i_mem_ready) begin
          o_pc_incr = 1'b1;
          operand_d = i_mem_data;
          state_d   = S_EXEC;
        end
      end
      S_EXEC: begin
        case (opcode)
          4'h2: o_pc_load = 1'b1;
          4'h3: o_pc_load = i_flag_z;
          4'h4: o_pc_load = i_flag_c;
          default: o_exec = 1'b1;
        endcase
        // Jumps always finish here; LDI/ALU ops wait for the datapath unless it is already done.
        if (!o_exec || i_exec_done) begin
          retire  = 1'b1;
          state_d = retire_state;
        end else begin
          state_d = S_EXEC_WAIT;
        end
      end
      S_EXEC_WAIT: begin
        if (i_exec_done) begin
          retire  = 1'b1;
          state_d = retire_state;
        end
      end
      default: state_d = S_HALT;
    endcase

    retired_d = retire ? retired_q + CNT_W'(1) : retired_q;
  end

  assign o_pc_oe     = o_mem_req;
  assign o_jump_addr = operand_q;
  assign o_ir        = ir_q;
  assign o_operand   = operand_q;
  assign o_retired   = retired_q;

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Fetch/decode/execute controller for the 8-bit core. It sequences the program counter (increment, output enable, load), the instruction and operand fetch over the memory handshake, and the hand-off to the ALU datapath.
- It sits between the program counter, the memory interface and the datapath. It is the only driver of the PC control strobes.
- The instruction byte is [7:4] opcode and [3:0] datapath-specific field.
- Opcodes 0x1–0x4 are two-byte instructions; the second byte is the operand.

Parameters:
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- i_clk  in  1  clock; all state changes on the rising edge.
- i_reset  in  1  asynchronous reset, active-low; 0 forces reset state immediately.
- i_run  in  1  run request; a rising edge, sampled registered, leaves HALT.
- i_mem_data  in  8  memory read data, valid while i_mem_ready=1.
- i_mem_ready  in  1  memory read complete in this cycle.
- o_mem_req  out  1  memory read request; held until i_mem_ready.
- o_pc_oe  out  1  PC drives the address bus; equals o_mem_req.
- o_pc_incr  out  1  PC increment strobe.
- o_pc_load  out  1  PC load strobe; PC data input = o_jump_addr.
- o_jump_addr  out  8  jump target; equals the operand register.
- o_ir  out  8  instruction register.
- o_operand  out  8  operand register.
- o_exec  out  1  one-cycle pulse: datapath executes o_ir/o_operand.
- i_exec_done  in  1  datapath finished; may be asserted in the same cycle as o_exec.
- i_flag_z  in  1  zero flag, sampled in EXEC.
- i_flag_c  in  1  carry flag, sampled in EXEC.
- o_halted  out  1  1 in HALT state.
- o_retired  out  CNT_W  retired-instruction count; wraps at all-ones to 0.

Behaviour:
- Reset (i_reset=0, any state, mid-handshake included):
  - state=HALT, o_ir=0, o_operand=0, o_retired=0, run_q=0.
  - All strobes 0; o_halted=1.
- States: HALT, FETCH, DECODE, OPND, EXEC, EXEC_WAIT.
- HALT:
  - Go to FETCH when i_run=1 and run_q=0. run_q is i_run registered and resets to 0, so i_run held high through reset starts execution.
- FETCH:
  - o_mem_req=o_pc_oe=1.
  - In the cycle i_mem_ready=1: o_pc_incr=1 (combinational), o_ir<=i_mem_data, next state DECODE.
  - Otherwise stay in FETCH with no strobes besides the request. Zero wait states is legal: ready in the first FETCH cycle.
- DECODE: one cycle, no strobes.
  - 0x0 NOP: retire, go to FETCH.
  - 0xF HLT: retire, go to HALT.
  - 0x1 LDI, 0x2 JMP, 0x3 JZ, 0x4 JC: go to OPND.
  - Any other opcode: go to EXEC.
- OPND:
  - Same handshake as FETCH.
  - On ready: o_pc_incr=1, o_operand<=i_mem_data, go to EXEC.
- EXEC: one cycle.
  - JMP, or JZ with i_flag_z=1, or JC with i_flag_c=1: o_pc_load=1, retire, go to FETCH.
  - JZ/JC not taken: no load (PC already points past the operand), retire, go to FETCH.
  - LDI and ALU opcodes: o_exec=1. If i_exec_done=1 this cycle: retire, go to FETCH. Otherwise go to EXEC_WAIT.
- EXEC_WAIT:
  - Hold until i_exec_done=1, then retire and go to FETCH.
  - No further o_exec pulse.
- Retire: o_retired increments by 1 on the transition edge.
- Latency: single-byte op with zero-wait memory and immediate done takes 3 cycles (FETCH, DECODE, EXEC); NOP/HLT take 2; two-byte ops take 4.
- PC wrap from 0xFF to 0x00 is handled by the PC; the sequencer performs no check, and an operand at 0xFF is fetched from 0xFF.
- i_run deasserted mid-instruction has no effect; only HLT enters HALT, unless the optional feature is compiled in.
- o_pc_incr and o_pc_load are never asserted in the same cycle.

Optional Feature:
- Macro: INSTR_SEQ_STEP_EN.
- When defined:
  - Adds input i_step (1 bit).
  - In HALT with i_run=0, a rising edge of i_step (registered, reset 0) executes exactly one instruction, then returns to HALT.
  - Also when defined: i_run=0 at any retire forces HALT instead of FETCH.
- When undefined: no i_step port; behaviour as above.

Test Plan:
- Reset with i_run=1 held, memory {0x00@0x00, 0xF0@0x01}, zero-wait: FETCH at cycle 1; exactly 2 o_pc_incr pulses; HALT with o_retired=2.
- JMP: mem 0x20,0x80 at 0x00; 0xF0 at 0x80 → o_pc_load pulse with o_jump_addr=0x80 in EXEC; next fetch address 0x80; HALT with o_retired=2.
- JZ with i_flag_z=0: mem 0x30,0x80 → no o_pc_load; next fetch at 0x02.
- JZ with i_flag_z=1: mem 0x30,0x80 → o_pc_load=1, next fetch at 0x80.
- ALU op 0x57 with i_exec_done delayed 3 cycles → single o_exec pulse; EXEC_WAIT for 3 cycles; o_retired increments on the done edge.
- Memory i_mem_ready delayed 4 cycles → o_mem_req/o_pc_oe held 5 cycles; exactly one o_pc_incr, in the ready cycle.
- i_reset=0 asserted mid-OPND wait → immediate HALT; o_ir=0, o_operand=0, o_mem_req=0 without waiting for a clock; restart on the next i_run rising edge.
